binary_search_engine: RTL and testbench

- Parametrised, self-contained binary-search engine: integrated controller plus datapath searching a sorted, ascending, synchronous-read RAM of 2**ADDR_W words of DATA_W bits.
- Adds a start/done handshake, a found/miss result with the matching index, configurable memory read latency, and a safe miss terminate on an empty interval.
- Sits between user logic and the read port of a single-port or dual-port RAM.

---
 rtl/bsearch_pkg.sv | 20 ++
 rtl/bsearch_datapath.sv | 97 +++++++++
 rtl/binary_search_engine.sv | 143 ++++++++++++++
 tb/tb_binary_search_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsearch_pkg.sv
// Shared types and constants for the binary search engine.
package bsearch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAIT,
        CMP,
        DONE
    } state_t;

    localparam int MAX_MEM_LATENCY = 4;
    localparam int CNT_W           = $clog2(MAX_MEM_LATENCY);

    // Signed interval bounds need room for R = -1 and L = DEPTH.
    function automatic int idx_width(input int addr_w);
        return addr_w + 2;
    endfunction

endpackage

// File: rtl/bsearch_datapath.sv
// Datapath for the binary search engine: target, interval bounds, probe
// index, read-latency counter, result registers and the comparator.
// Optional macro BSEARCH_LOWER_BOUND_EN adds the insert_pos output.
module bsearch_datapath
    import bsearch_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    input  logic              calc_m,
    input  logic              move_l,
    input  logic              move_r,
    input  logic              load_cnt,
    input  logic              dec_cnt,
    input  logic              set_found,
    input  logic [DATA_W-1:0] target_in,
    input  logic [DATA_W-1:0] mem_data,
    output logic              eq,
    output logic              lt,
    output logic              empty,
    output logic              wait_zero,
    output logic [ADDR_W-1:0] mid,
    output logic              found,
    output logic [ADDR_W-1:0] index
`ifdef BSEARCH_LOWER_BOUND_EN
    ,
    output logic [ADDR_W:0]   insert_pos
`endif
);

    localparam int IDX_W = idx_width(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic signed [IDX_W-1:0] HI_INIT  = IDX_W'(DEPTH - 1);
    localparam logic signed [IDX_W-1:0] ONE      = IDX_W'(1);
    localparam logic [CNT_W-1:0]        CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    logic [DATA_W-1:0]        target;
    logic signed [IDX_W-1:0]  lo;
    logic signed [IDX_W-1:0]  hi;
    logic signed [IDX_W-1:0]  mid_ext;
    logic [CNT_W-1:0]         cnt;

    assign mid_ext   = $signed({{(IDX_W - ADDR_W){1'b0}}, mid});
    assign eq        = (mem_data == target);
    assign lt        = (mem_data < target);
    assign empty     = (lo > hi);
    assign wait_zero = (cnt == '0);

`ifdef BSEARCH_LOWER_BOUND_EN
    // After a miss the lower bound has settled on the first word above target.
    assign insert_pos = found ? {1'b0, index} : lo[ADDR_W:0];
`endif

    // Register updates driven by the controller strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target <= '0;
            lo     <= '0;
            hi     <= '0;
            mid    <= '0;
            cnt    <= '0;
            found  <= 1'b0;
            index  <= '0;
        end else begin
            if (init) begin
                target <= target_in;
                lo     <= '0;
                hi     <= HI_INIT;
                found  <= 1'b0;
                index  <= '0;
            end
            if (calc_m) begin
                mid <= ADDR_W'((lo + hi) >>> 1);
            end
            if (move_l) begin
                lo <= mid_ext + ONE;
            end
            if (move_r) begin
                hi <= mid_ext - ONE;
            end
            if (load_cnt) begin
                cnt <= CNT_INIT;
            end else if (dec_cnt) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (set_found) begin
                found <= 1'b1;
                index <= mid;
            end
        end
    end

endmodule

// File: rtl/binary_search_engine.sv
// Binary search over a sorted synchronous-read RAM with start/done handshake.
// Optional macro BSEARCH_LOWER_BOUND_EN adds insert_pos (lower-bound result).
//
// state | meaning
// IDLE  | waiting for start
// CALC  | check for empty interval, compute probe index
// WAIT  | let the RAM read settle for MEM_LATENCY cycles
// CMP   | compare read word with target, narrow interval
// DONE  | one-cycle done pulse
module binary_search_engine
    import bsearch_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 5,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] target_in,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] index
`ifdef BSEARCH_LOWER_BOUND_EN
    ,
    output logic [ADDR_W:0]   insert_pos
`endif
);

    state_t state;
    state_t state_next;

    logic init;
    logic calc_m;
    logic move_l;
    logic move_r;
    logic load_cnt;
    logic dec_cnt;
    logic set_found;
    logic eq;
    logic lt;
    logic empty;
    logic wait_zero;

    bsearch_datapath #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEM_LATENCY (MEM_LATENCY)
    ) u_datapath (
        .clk        (clk),
        .reset_n    (reset_n),
        .init       (init),
        .calc_m     (calc_m),
        .move_l     (move_l),
        .move_r     (move_r),
        .load_cnt   (load_cnt),
        .dec_cnt    (dec_cnt),
        .set_found  (set_found),
        .target_in  (target_in),
        .mem_data   (mem_data),
        .eq         (eq),
        .lt         (lt),
        .empty      (empty),
        .wait_zero  (wait_zero),
        .mid        (mem_addr),
        .found      (found),
        .index      (index)
`ifdef BSEARCH_LOWER_BOUND_EN
        ,
        .insert_pos (insert_pos)
`endif
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        init       = 1'b0;
        calc_m     = 1'b0;
        move_l     = 1'b0;
        move_r     = 1'b0;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        set_found  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    init       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (empty) begin
                    state_next = DONE;
                end else begin
                    calc_m     = 1'b1;
                    load_cnt   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_zero) begin
                    state_next = CMP;
                end else begin
                    dec_cnt = 1'b1;
                end
            end
            CMP: begin
                if (eq) begin
                    set_found  = 1'b1;
                    state_next = DONE;
                end else if (lt) begin
                    move_l     = 1'b1;
                    state_next = CALC;
                end else begin
                    move_r     = 1'b1;
                    state_next = CALC;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_binary_search_engine.sv
// Scoreboard bench: two engines (read latency 1 and 3) share one sorted memory.
module tb_binary_search_engine;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct {
        int found_e;
        int index_e;
        int ins_e;
        int cycles_e;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]                    start;
    logic [1:0][DATA_W-1:0]        target;
    logic [1:0][ADDR_W-1:0]        mem_addr;
    logic [1:0]                    busy;
    logic [1:0]                    done;
    logic [1:0]                    found;
    logic [1:0][ADDR_W-1:0]        idx;
`ifdef BSEARCH_LOWER_BOUND_EN
    logic [1:0][ADDR_W:0]          ins;
`endif
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] p3a, p3b, p3c;
    logic [DATA_W-1:0] mem [DEPTH];

    int   lat_of [2] = '{1, 3};
    exp_t q0 [$];
    exp_t q1 [$];
    int   bcnt [2] = '{0, 0};
    int   n_tests = 0;
    int   n_fail  = 0;

    binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LATENCY(1)) u_lat1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start[0]),
        .target_in  (target[0]),
        .mem_addr   (mem_addr[0]),
        .mem_data   (rd1),
        .busy       (busy[0]),
        .done       (done[0]),
        .found      (found[0]),
        .index      (idx[0])
`ifdef BSEARCH_LOWER_BOUND_EN
        ,
        .insert_pos (ins[0])
`endif
    );

    binary_search_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LATENCY(3)) u_lat3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start[1]),
        .target_in  (target[1]),
        .mem_addr   (mem_addr[1]),
        .mem_data   (p3c),
        .busy       (busy[1]),
        .done       (done[1]),
        .found      (found[1]),
        .index      (idx[1])
`ifdef BSEARCH_LOWER_BOUND_EN
        ,
        .insert_pos (ins[1])
`endif
    );

    // Synchronous RAM read ports with 1 and 3 cycles of latency.
    always @(posedge clk) begin
        rd1 <= mem[mem_addr[0]];
        p3a <= mem[mem_addr[1]];
        p3b <= p3a;
        p3c <= p3b;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: linear scan for result, plain halving loop for probe count.
    function automatic exp_t model(input int t, input int lat);
        exp_t e;
        int lo, hi, mid, p;
        bit hit;
        e.found_e = 0;
        e.index_e = 0;
        e.ins_e   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(mem[i]) == t) begin
                e.found_e = 1;
                e.index_e = i;
            end
            if (int'(mem[i]) < t) e.ins_e++;
        end
        lo = 0; hi = DEPTH - 1; p = 0; hit = 0;
        while (lo <= hi && !hit) begin
            mid = (lo + hi) / 2;
            p++;
            if (int'(mem[mid]) == t) hit = 1;
            else if (int'(mem[mid]) < t) lo = mid + 1;
            else hi = mid - 1;
        end
        e.cycles_e = p * (lat + 2) + (hit ? 1 : 2);
        return e;
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int s, input exp_t e);
        if (s == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    function automatic exp_t qpop(input int s);
        if (s == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Monitor: on each done pulse pop the oldest expectation and compare.
    always @(negedge clk) begin
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (!reset_n) begin
                bcnt[s] = 0;
            end else begin
                if (busy[s]) bcnt[s]++;
                if (done[s]) begin
                    chk($sformatf("pending_at_done%0d", s), (qsize(s) > 0) ? 1 : 0, 1);
                    if (qsize(s) > 0) begin
                        e = qpop(s);
                        chk($sformatf("found%0d", s), found[s], e.found_e);
                        chk($sformatf("index%0d", s), idx[s], e.index_e);
                        chk($sformatf("busy_cycles%0d", s), bcnt[s], e.cycles_e);
`ifdef BSEARCH_LOWER_BOUND_EN
                        chk($sformatf("insert_pos%0d", s), ins[s], e.ins_e);
`endif
                    end
                    bcnt[s] = 0;
                end
            end
        end
    end

    task automatic issue(input int s, input int t);
        @(negedge clk);
        start[s]  = 1'b1;
        target[s] = DATA_W'(t);
        qpush(s, model(t, lat_of[s]));
        @(negedge clk);
        start[s] = 1'b0;
    endtask

    task automatic wait_idle(input int s);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((qsize(s) != 0 || busy[s]) && n < 300);
        chk($sformatf("idle_timeout%0d", s), (qsize(s) == 0 && !busy[s]) ? 1 : 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("%s_busy%0d", tag, s), busy[s], 0);
            chk($sformatf("%s_done%0d", tag, s), done[s], 0);
            chk($sformatf("%s_found%0d", tag, s), found[s], 0);
            chk($sformatf("%s_index%0d", tag, s), idx[s], 0);
            chk($sformatf("%s_addr%0d", tag, s), mem_addr[s], 0);
`ifdef BSEARCH_LOWER_BOUND_EN
            chk($sformatf("%s_ins%0d", tag, s), ins[s], 0);
`endif
        end
    endtask

    initial begin
        int n;
        int v;
        start  = '0;
        target = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(2 * i + 1);

        repeat (2) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;

        // Directed searches on mem[i] = 2i+1, both latencies.
        for (int s = 0; s < 2; s++) begin
            issue(s, 31); wait_idle(s);
            if (s == 0) begin
                repeat (3) @(negedge clk);
                chk("found_hold", found[0], 1);
                chk("index_hold", idx[0], 15);
            end
            issue(s, 21);  wait_idle(s);
            issue(s, 4);   wait_idle(s);
            issue(s, 0);   wait_idle(s);
            issue(s, 200); wait_idle(s);
            issue(s, 63);  wait_idle(s);
        end

        // A second start mid-search is ignored.
        issue(0, 21);
        repeat (2) @(negedge clk);
        start[0] = 1'b1; target[0] = 8'd63;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);

        // Asynchronous reset between edges while the engine is waiting on RAM.
        issue(0, 21);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero("async_reset");
        q0.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        issue(0, 63); wait_idle(0);

        // Back-to-back: start on the done cycle ignored, next cycle accepted.
        issue(0, 31);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!done[0] && n < 50);
        chk("b2b_done_seen", done[0], 1);
        start[0] = 1'b1; target[0] = 8'd5;
        @(negedge clk);
        #1;
        chk("b2b_found_held", found[0], 1);
        chk("b2b_index_held", idx[0], 15);
        target[0] = 8'd9;
        qpush(0, model(9, 1));
        @(negedge clk);
        #1;
        start[0] = 1'b0;
        chk("b2b_busy", busy[0], 1);
        chk("b2b_found_clr", found[0], 0);
        chk("b2b_index_clr", idx[0], 0);
        wait_idle(0);

        // Random sorted memories and targets.
        for (int r = 0; r < 60; r++) begin
            if (r % 10 == 0) begin
                v = $urandom_range(0, 3);
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] = DATA_W'(v);
                    v += $urandom_range(1, 7);
                end
            end
            if ($urandom_range(0, 1) == 1) v = int'(mem[$urandom_range(0, DEPTH - 1)]);
            else v = $urandom_range(0, 255);
            issue(r % 2, v);
            wait_idle(r % 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
